// File: rtl/booth_multiplier_pkg.sv
// Shared definitions for the radix-2 Booth multiplier: default operand width,
// FSM state encoding and the Booth recoding decode helper.
package booth_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_e;

    // Radix-2 Booth recoding of the pair {Q0, Q(-1)}.
    function automatic booth_op_e booth_decode(input logic q0, input logic qm1);
        booth_op_e op;
        case ({q0, qm1})
            2'b01:   op = OP_ADD;
            2'b10:   op = OP_SUB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_multiplier_if.sv
// Operand/result bundle between a requester (master) and the multiplier (slave).
interface booth_multiplier_if #(
    parameter int WIDTH = 16
) ();

    logic                   en;
    logic [WIDTH-1:0]       A;
    logic [WIDTH-1:0]       B;
    logic [2*WIDTH-1:0]     Prod;
    logic                   done;

    modport master (
        output en,
        output A,
        output B,
        input  Prod,
        input  done
    );

    modport slave (
        input  en,
        input  A,
        input  B,
        output Prod,
        output done
    );

endinterface

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the accumulator followed by an arithmetic right shift of
// {accumulator, Q, Q(-1)}. Purely combinational.
module booth_step
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   acc_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic             qm1_i,
    input  logic [WIDTH-1:0] mcand_i,
    output logic [WIDTH:0]   acc_o,
    output logic [WIDTH-1:0] q_o,
    output logic             qm1_o
);

    logic [WIDTH:0] mcand_ext_s;
    logic [WIDTH:0] sum_s;
    booth_op_e      op_s;

    // Add/subtract the sign-extended multiplicand, then shift right by one.
    always_comb begin
        mcand_ext_s = {mcand_i[WIDTH-1], mcand_i};
        op_s        = booth_decode(q_i[0], qm1_i);
        case (op_s)
            OP_ADD:  sum_s = acc_i + mcand_ext_s;
            OP_SUB:  sum_s = acc_i - mcand_ext_s;
            default: sum_s = acc_i;
        endcase
        acc_o = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_o   = {sum_s[0], q_i[WIDTH-1:1]};
        qm1_o = q_i[0];
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier using radix-2 Booth recoding, one multiplier
// bit per clock. Operands are captured on start so they may change while busy;
// the product and done flag are registered and Prod only moves on completion
// or reset.
module booth_multiplier
    import booth_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    booth_multiplier_if.slave    bus
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH:0]     acc_q;
    logic [WIDTH-1:0]   q_q;
    logic               qm1_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               done_q;

    logic [WIDTH:0]     acc_d;
    logic [WIDTH-1:0]   q_d;
    logic               qm1_d;

    booth_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc_i   (acc_q),
        .q_i     (q_q),
        .qm1_i   (qm1_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_d),
        .q_o     (q_d),
        .qm1_o   (qm1_d)
    );

    // Control FSM, iteration counter, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.en) begin
                        mcand_q <= bus.A;
                        q_q     <= bus.B;
                        acc_q   <= '0;
                        qm1_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_BUSY;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    acc_q <= acc_d;
                    q_q   <= q_d;
                    qm1_q <= qm1_d;
                    if (cnt_q == CNT_LAST) begin
                        // Last iteration: the product is the freshly shifted value.
                        prod_q  <= {acc_d[WIDTH-1:0], q_d};
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CNT_W'(1);
                        state_q <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    // Hold the result until the requester drops en.
                    if (bus.en) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Prod = prod_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed bench for booth_multiplier with hand-computed products.
module tb_booth_multiplier;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    booth_multiplier_if #(.WIDTH(W)) bus ();

    booth_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Start an operation, wait for done, check latency/result, optionally hold
    // en high in DONE, then drop en and check return to idle.
    task automatic run_op(input string tag, input logic signed [15:0] a,
                          input logic signed [15:0] b, input logic signed [31:0] exp,
                          input int hold, input bit scramble);
        logic [31:0] prev;
        int edges;
        prev   = bus.Prod;
        bus.A  = a;
        bus.B  = b;
        bus.en = 1'b1;
        check({tag, "/idle_done"}, {31'd0, bus.done}, 32'd0);
        step();  // edge that samples en=1 (edge 1 of the 17)
        edges = 0;
        if (scramble) begin
            bus.A  = 16'sh7FFF;
            bus.B  = 16'sh1235;
            bus.en = 1'b0;
        end
        while (bus.done !== 1'b1 && edges < 40) begin
            if (edges == 4) check({tag, "/prod_hold_busy"}, bus.Prod, prev);
            step();
            edges++;
        end
        // Done must rise on edge 17 counting the sampling edge, i.e. 16 later.
        check({tag, "/latency"}, 32'(edges), 32'd16);
        check({tag, "/prod"}, bus.Prod, exp);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "/hold_done"}, {31'd0, bus.done}, 32'd1);
            check({tag, "/hold_prod"}, bus.Prod, exp);
        end
        bus.en = 1'b0;
        step();
        check({tag, "/done_clear"}, {31'd0, bus.done}, 32'd0);
        check({tag, "/prod_keep"}, bus.Prod, exp);
    endtask

    initial begin
        rst_n  = 1'b0;
        bus.en = 1'b0;
        bus.A  = 16'd0;
        bus.B  = 16'd0;
        step();
        step();
        check("reset/prod", bus.Prod, 32'd0);
        check("reset/done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;

        // en held high for 50 cycles: one computation, result held in DONE.
        run_op("12x5", 16'sd12, 16'sd5, 32'sd60, 33, 1'b0);

        run_op("m15xm10", -16'sd15, -16'sd10, 32'sd150, 0, 1'b0);
        run_op("m9x11", -16'sd9, 16'sd11, -32'sd99, 0, 1'b0);
        run_op("m10xm34", -16'sd10, -16'sd34, 32'sd340, 0, 1'b0);
        run_op("minxmin", -16'sd32768, -16'sd32768, 32'sd1073741824, 0, 1'b0);
        run_op("maxxmin", 16'sd32767, -16'sd32768, -32'sd1073709056, 0, 1'b0);
        run_op("0xm1", 16'sd0, -16'sd1, 32'sd0, 0, 1'b0);
        run_op("m1x0", -16'sd1, 16'sd0, 32'sd0, 0, 1'b0);
        run_op("300x3", 16'sd300, 16'sd3, 32'sd900, 0, 1'b0);

        // Reset in the middle of BUSY aborts the operation.
        bus.A  = 16'sd100;
        bus.B  = 16'sd3;
        bus.en = 1'b1;
        step();                           // sampling edge
        for (int i = 0; i < 7; i++) step(); // BUSY cycles 1..7
        rst_n  = 1'b0;
        bus.en = 1'b0;
        step();                           // BUSY cycle 8 edge with reset low
        check("abort/done", {31'd0, bus.done}, 32'd0);
        check("abort/prod", bus.Prod, 32'd0);
        rst_n = 1'b1;
        run_op("7x7_after_reset", 16'sd7, 16'sd7, 32'sd49, 0, 1'b0);

        // Operands and en disturbed during BUSY must not affect the result.
        run_op("scramble_m123x45", -16'sd123, 16'sd45, -32'sd5535, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
